// File: rtl/prog_loader.sv
// prog_loader: sequences the shared 8-bit bus to write a program image into
// the RAM while the core is frozen, then restarts the core at address 0.
// Each byte costs three cycles: FETCH (handshake), ADDR (mi), DATA (ri).
// Optional feature: define LOADER_CSUM_EN to require a trailing modulo-256
// checksum byte; a mismatch sets err and keeps the core frozen.
module prog_loader #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [4:0]        len,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] bus_out,
    output logic              bus_oe,
    output logic              mi,
    output logic              ri,
    output logic              core_hold,
    output logic              core_rst,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int LEN_W = 5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HOLD,
        S_FETCH,
        S_ADDR,
        S_DATA,
        S_RELEASE,
        S_DONE
`ifdef LOADER_CSUM_EN
        , S_CSUM
`endif
    } state_t;

    state_t            state, state_d;
    logic [LEN_W-1:0]  n_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] byte_q;
    logic              hold_c;
    logic              last_byte;
    logic [LEN_W-1:0]  len_clamped;

    assign len_clamped = (len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : len;
    assign last_byte   = (LEN_W'(addr_q) == n_q - LEN_W'(1));

`ifdef LOADER_CSUM_EN
    logic [DATA_W-1:0] sum_q;
    logic              err_q;
    logic              lock_q;   // keeps the core frozen after a bad image

    assign err       = err_q;
    assign core_hold = hold_c | lock_q;
`else
    assign err       = 1'b0;
    assign core_hold = hold_c;
`endif

    // State register plus the datapath registers each state owns.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values and simulation matches hardware.
        if (rst) begin
            state  <= S_IDLE;
            n_q    <= '0;
            addr_q <= '0;
            byte_q <= '0;
`ifdef LOADER_CSUM_EN
            sum_q  <= '0;
            err_q  <= 1'b0;
            lock_q <= 1'b0;
`endif
        end else begin
            state <= state_d;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        n_q    <= len_clamped;
                        addr_q <= '0;
`ifdef LOADER_CSUM_EN
                        sum_q  <= '0;
                        err_q  <= 1'b0;
`endif
                    end
                end
                S_FETCH: begin
                    if (in_valid) byte_q <= in_data;
                end
                S_DATA: begin
                    if (!last_byte) addr_q <= addr_q + ADDR_W'(1);
`ifdef LOADER_CSUM_EN
                    sum_q <= sum_q + byte_q;
`endif
                end
`ifdef LOADER_CSUM_EN
                S_CSUM: begin
                    if (in_valid) begin
                        if (in_data == sum_q) begin
                            lock_q <= 1'b0;
                        end else begin
                            err_q  <= 1'b1;
                            lock_q <= 1'b1;
                        end
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    // Next-state and Moore outputs decoded from the current state.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        state_d  = state;
        in_ready = 1'b0;
        bus_out  = '0;
        bus_oe   = 1'b0;
        mi       = 1'b0;
        ri       = 1'b0;
        hold_c   = 1'b0;
        core_rst = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_d = S_HOLD;
            end
            S_HOLD: begin
                hold_c = 1'b1;
                busy   = 1'b1;
`ifdef LOADER_CSUM_EN
                state_d = (n_q == '0) ? S_CSUM : S_FETCH;
`else
                state_d = (n_q == '0) ? S_RELEASE : S_FETCH;
`endif
            end
            S_FETCH: begin
                hold_c   = 1'b1;
                busy     = 1'b1;
                in_ready = 1'b1;
                if (in_valid) state_d = S_ADDR;
            end
            S_ADDR: begin
                hold_c  = 1'b1;
                busy    = 1'b1;
                bus_oe  = 1'b1;
                mi      = 1'b1;
                bus_out = DATA_W'(addr_q);
                state_d = S_DATA;
            end
            S_DATA: begin
                hold_c  = 1'b1;
                busy    = 1'b1;
                bus_oe  = 1'b1;
                ri      = 1'b1;
                bus_out = byte_q;
`ifdef LOADER_CSUM_EN
                state_d = last_byte ? S_CSUM : S_FETCH;
`else
                state_d = last_byte ? S_RELEASE : S_FETCH;
`endif
            end
`ifdef LOADER_CSUM_EN
            S_CSUM: begin
                hold_c   = 1'b1;
                busy     = 1'b1;
                in_ready = 1'b1;
                if (in_valid) state_d = (in_data == sum_q) ? S_RELEASE : S_IDLE;
            end
`endif
            S_RELEASE: begin
                hold_c   = 1'b1;
                busy     = 1'b1;
                core_rst = 1'b1;
                state_d  = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: randomized scoreboard bench for prog_loader. The stimulus
// pushes the expected bus writes and restart/done events; a monitor pops
// them as the DUT produces them. Follows LOADER_CSUM_EN if defined.
module tb_prog_loader;

    localparam int DEPTH = 16;
`ifdef LOADER_CSUM_EN
    localparam bit CSUM_BUILD = 1'b1;
`else
    localparam bit CSUM_BUILD = 1'b0;
`endif

    typedef enum int {EV_WR, EV_RST, EV_DONE} ev_kind_t;
    typedef struct {
        ev_kind_t   kind;
        logic [3:0] addr;
        logic [7:0] data;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst, start, in_valid;
    logic [4:0] len;
    logic [7:0] in_data;
    logic       in_ready, bus_oe, mi, ri, core_hold, core_rst, busy, done, err;
    logic [7:0] bus_out;

    int         n_checks = 0;
    int         n_pass   = 0;
    int         cyc      = 0;
    ev_t        sb[$];
    logic [3:0] mon_addr = '0;
    logic [7:0] data_mem [32];
`ifdef LOADER_CSUM_EN
    logic [7:0] csum_delta = '0;
`endif

    prog_loader dut (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .bus_out(bus_out), .bus_oe(bus_oe), .mi(mi), .ri(ri),
        .core_hold(core_hold), .core_rst(core_rst), .busy(busy),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic push_ev(input ev_kind_t k, input logic [3:0] a, input logic [7:0] d);
        ev_t e;
        e.kind = k; e.addr = a; e.data = d;
        sb.push_back(e);
    endtask

    task automatic pop_expect(input ev_kind_t k, input logic [3:0] a, input logic [7:0] d);
        ev_t e;
        if (sb.size() == 0) begin
            check("sb_unexpected_event", k, 32'hFFFF_FFFF);
        end else begin
            e = sb.pop_front();
            check("sb_event_kind", k, e.kind);
            if (e.kind == EV_WR && k == EV_WR) begin
                check("wr_addr", a, e.addr);
                check("wr_data", d, e.data);
            end
        end
    endtask

    // Monitor: bus ownership rules and scoreboard matching, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (mi || ri) begin
                check("mi_ri_exclusive", mi & ri, 0);
                check("oe_with_strobe", bus_oe, 1);
                check("hold_while_oe", core_hold, 1);
            end else if (bus_oe) begin
                check("oe_without_strobe", bus_oe, 0);
            end
            if (mi) begin
                check("addr_upper_zero", bus_out[7:4], 0);
                mon_addr = bus_out[3:0];
            end
            if (ri)       pop_expect(EV_WR, mon_addr, bus_out);
            if (core_rst) pop_expect(EV_RST, 4'h0, 8'h00);
            if (done)     pop_expect(EV_DONE, 4'h0, 8'h00);
        end
    end

    // Polls at posedge+1 until in_ready, bounded.
    task automatic wait_ready();
        int cnt = 0;
        while (!in_ready && cnt < 100) begin
            @(posedge clk); #1;
            cnt++;
        end
        if (!in_ready) check("ready_timeout", 0, 1);
    endtask

    // Hands one byte over, optionally holding in_valid low for `stall` FETCH cycles.
    task automatic feed_byte(input logic [7:0] b, input int stall);
        in_valid = 1'b0;
        if (stall > 0) begin
            wait_ready();
            for (int s = 0; s < stall; s++) begin
                check("stall_ready", in_ready, 1);
                check("stall_no_bus", {bus_oe, mi, ri}, 0);
                @(posedge clk); #1;
            end
        end
        in_data  = b;
        in_valid = 1'b1;
        wait_ready();
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // One full load of data_mem[0..]; called at posedge+1 time.
    task automatic run_load(input int len_in, input int stall, input int exp_cycles);
        int         n, t0, cnt;
        logic [7:0] sum;
        bit         good;
        n    = (len_in > DEPTH) ? DEPTH : len_in;
        sum  = '0;
        good = 1'b1;
`ifdef LOADER_CSUM_EN
        good = (csum_delta == 8'h00);
`endif
        start = 1'b1;
        len   = 5'(len_in);
        t0    = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            push_ev(EV_WR, 4'(i), data_mem[i]);
            sum = sum + data_mem[i];
            feed_byte(data_mem[i], stall);
        end
`ifdef LOADER_CSUM_EN
        feed_byte(sum + csum_delta, stall);
`endif
        if (good) begin
            push_ev(EV_RST, 4'h0, 8'h00);
            push_ev(EV_DONE, 4'h0, 8'h00);
        end
        cnt = 0;
        while ((good ? !done : busy) && cnt < 400) begin
            @(posedge clk); #1;
            cnt++;
        end
        if (cnt >= 400) check("load_timeout", 0, 1);
        if (good) begin
            if (exp_cycles > 0) check("start_to_done_cycles", cyc - t0 + 1, exp_cycles);
            check("done_err_clear", err, 0);
            check("done_releases", {core_hold, busy}, 0);
        end else begin
            check("bad_csum_err", err, 1);
            check("bad_csum_hold", core_hold, 1);
            @(posedge clk); #1;
            check("bad_csum_hold_stays", core_hold, 1);
        end
        @(posedge clk); #1;
        check("sb_drained", sb.size(), 0);
    endtask

    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++) data_mem[i] = 8'($urandom);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; len = '0; in_data = '0; in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_outputs",
              {in_ready, bus_out, bus_oe, mi, ri, core_hold, core_rst, busy, done, err}, 0);

        // Reset mid-FETCH of a len=4 load: byte 0 written, then aborted.
        data_mem[0] = 8'hA5;
        start = 1'b1; len = 5'd4;
        @(posedge clk); #1;
        start = 1'b0;
        push_ev(EV_WR, 4'h0, 8'hA5);
        feed_byte(8'hA5, 0);
        wait_ready();
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_releases_hold", core_hold, 0);
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b0;
        check("after_rst_outputs",
              {in_ready, bus_out, bus_oe, mi, ri, core_hold, core_rst, busy, done, err}, 0);
        check("after_rst_sb", sb.size(), 0);
        fill_random(1);
        run_load(1, 0, 0);

        // Directed len=3 stream, in_valid continuously high.
        data_mem[0] = 8'h1E; data_mem[1] = 8'h2F; data_mem[2] = 8'hF0;
        run_load(3, 0, CSUM_BUILD ? 0 : 13);

        // Stalled FETCH: in_valid low for 5 cycles before each byte.
        fill_random(2);
        run_load(2, 5, 0);

        // Over-length clamps to 16 writes; zero length does no writes.
        fill_random(20);
        run_load(20, 0, 0);
        run_load(0, 0, CSUM_BUILD ? 0 : 4);

        // start during DATA of an active load is ignored.
        fill_random(4);
        fork
            run_load(4, 0, 0);
            begin
                int seen = 0, cnt = 0;
                while (seen < 2 && cnt < 100) begin
                    @(posedge clk); #1;
                    if (ri) seen++;
                    cnt++;
                end
                if (seen < 2) check("ri_wait_timeout", 0, 1);
                start = 1'b1; len = 5'd1;
                @(posedge clk); #1;
                start = 1'b0;
            end
        join

`ifdef LOADER_CSUM_EN
        data_mem[0] = 8'h80; data_mem[1] = 8'h90;
        run_load(2, 0, 0);
        csum_delta = 8'h01;
        run_load(2, 0, 0);
        csum_delta = 8'h00;
        run_load(2, 1, 0);
`endif

        // Randomized loads.
        for (int k = 0; k < 8; k++) begin
            fill_random(20);
            run_load(int'($urandom_range(0, 20)), int'($urandom_range(0, 3)), 0);
        end

        repeat (4) @(posedge clk);
        #1;
        check("final_sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
